// File: rtl/dot4x_clk_ctrl.sv
// Clock controller for the dot4x domain: PLL reset/lock sequencing, lock supervision and glitch-guarded
// NTSC/PAL clock-select switching. Define CLKGEN_LOCK_TIMEOUT_EN to retry the PLL after a lock timeout.
module dot4x_clk_ctrl #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 4096,
    parameter int STABLE_CYCLES  = 256,
    parameter int SWITCH_CYCLES  = 8
) (
    input  logic       clk_col8x,
    input  logic       rst,
    input  logic       chip_model,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       clk_sel,
    output logic       sys_rst,
    output logic       ready,
    output logic [3:0] retry_cnt,
    output logic [2:0] o_dbg_state
);

    localparam int MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_B = (STABLE_CYCLES > SWITCH_CYCLES) ? STABLE_CYCLES : SWITCH_CYCLES;
    localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W = $clog2(MAX_P + 1);

    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_SW_PRE    = 3'd4,
        S_SW_POST   = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_sync;
    logic               w_locked_s;
    logic               r_pll_rst;
    logic               r_sys_rst;
    logic               r_ready;
    logic               r_clk_sel;
    logic               w_sel_update;

    // pll_locked comes from the PLL with no timing relationship to clk_col8x.
    always_ff @(posedge clk_col8x) begin
        if (rst) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], pll_locked};
        end
    end

    assign w_locked_s = r_sync[1];

    always_comb begin
        w_next       = r_state;
        w_sel_update = 1'b0;
        case (r_state)
            S_PLL_RST: begin
                if (r_cnt == CNT_W'(PLL_RST_CYCLES - 1)) w_next = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (w_locked_s) w_next = S_STABLE;
`ifdef CLKGEN_LOCK_TIMEOUT_EN
                else if (r_cnt == CNT_W'(LOCK_TIMEOUT - 1)) w_next = S_PLL_RST;
`endif
            end
            S_STABLE: begin
                if (!w_locked_s) w_next = S_WAIT_LOCK;
                else if (r_cnt == CNT_W'(STABLE_CYCLES - 1)) w_next = S_RUN;
            end
            S_RUN: begin
                if (!w_locked_s) w_next = S_PLL_RST;
                else if (chip_model != r_clk_sel) w_next = S_SW_PRE;
            end
            S_SW_PRE: begin
                if (!w_locked_s) begin
                    w_next = S_PLL_RST;
                end else if (r_cnt == CNT_W'(SWITCH_CYCLES - 1)) begin
                    w_next       = S_SW_POST;
                    w_sel_update = 1'b1;
                end
            end
            S_SW_POST: begin
                if (!w_locked_s) w_next = S_PLL_RST;
                else if (r_cnt == CNT_W'(SWITCH_CYCLES - 1)) w_next = S_RUN;
            end
            default: w_next = S_PLL_RST;
        endcase
    end

    // Outputs are registered decodes of the next state, so they line up with the state they belong to.
    always_ff @(posedge clk_col8x) begin
        if (rst) begin
            r_state   <= S_PLL_RST;
            r_cnt     <= '0;
            r_pll_rst <= 1'b1;
            r_sys_rst <= 1'b1;
            r_ready   <= 1'b0;
            r_clk_sel <= chip_model;
        end else begin
            r_state   <= w_next;
            r_pll_rst <= (w_next == S_PLL_RST);
            r_sys_rst <= (w_next != S_RUN);
            r_ready   <= (w_next == S_RUN);
            if (w_sel_update) r_clk_sel <= chip_model;
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if (r_cnt != {CNT_W{1'b1}}) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

`ifdef CLKGEN_LOCK_TIMEOUT_EN
    logic [3:0] r_retry;

    always_ff @(posedge clk_col8x) begin
        if (rst) begin
            r_retry <= 4'd0;
        end else if ((r_state == S_WAIT_LOCK) && (w_next == S_PLL_RST) && (r_retry != 4'hF)) begin
            r_retry <= r_retry + 4'd1;
        end
    end

    assign retry_cnt = r_retry;
`else
    assign retry_cnt = 4'd0;
`endif

    assign pll_rst     = r_pll_rst;
    assign clk_sel     = r_clk_sel;
    assign sys_rst     = r_sys_rst;
    assign ready       = r_ready;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dot4x_clk_ctrl.sv
// Directed bench for dot4x_clk_ctrl: start-up, lock glitch in STABLE, model switch, lock loss, reset in RUN,
// and the lock-timeout retry path when CLKGEN_LOCK_TIMEOUT_EN is defined.
module tb_dot4x_clk_ctrl;

    localparam logic [2:0] ST_PLL_RST   = 3'd0;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] ST_STABLE    = 3'd2;
    localparam logic [2:0] ST_SW_PRE    = 3'd4;

    logic       clk_col8x;
    logic       rst;
    logic       chip_model;
    logic       pll_locked;
    logic       pll_rst;
    logic       clk_sel;
    logic       sys_rst;
    logic       ready;
    logic [3:0] retry_cnt;
    logic [2:0] dbg_state;

    int checks;
    int errors;
    int cyc;

    dot4x_clk_ctrl dut (
        .clk_col8x  (clk_col8x),
        .rst        (rst),
        .chip_model (chip_model),
        .pll_locked (pll_locked),
        .pll_rst    (pll_rst),
        .clk_sel    (clk_sel),
        .sys_rst    (sys_rst),
        .ready      (ready),
        .retry_cnt  (retry_cnt),
        .o_dbg_state(dbg_state)
    );

    initial clk_col8x = 1'b0;
    always #5 clk_col8x = ~clk_col8x;

    task automatic tick();
        @(posedge clk_col8x);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        cyc        = 0;
        rst        = 1'b1;
        chip_model = 1'b0;
        pll_locked = 1'b0;

        // Start-up: lock appears at cycle 30, ready after sync + 256 stable cycles.
        do_reset();
        check("rst_pll_rst", 16'(pll_rst), 16'd1);
        check("rst_sys_rst", 16'(sys_rst), 16'd1);
        check("rst_ready", 16'(ready), 16'd0);
        check("rst_retry", 16'(retry_cnt), 16'd0);
        check("rst_clk_sel", 16'(clk_sel), 16'd0);
        check("rst_state", 16'(dbg_state), 16'(ST_PLL_RST));
        run_to(15);
        check("pll_rst_c15", 16'(pll_rst), 16'd1);
        tick();
        check("pll_rst_c16", 16'(pll_rst), 16'd0);
        check("sys_rst_c16", 16'(sys_rst), 16'd1);
        run_to(30);
        pll_locked = 1'b1;
        run_to(288);
        check("ready_c288", 16'(ready), 16'd0);
        tick();
        check("ready_c289", 16'(ready), 16'd1);
        check("sys_rst_c289", 16'(sys_rst), 16'd0);
        check("clk_sel_c289", 16'(clk_sel), 16'd0);

        // Model switch NTSC -> PAL in RUN.
        run_to(300);
        chip_model = 1'b1;
        tick();
        check("sw_sys_rst_t1", 16'(sys_rst), 16'd1);
        check("sw_ready_t1", 16'(ready), 16'd0);
        check("sw_clk_sel_t1", 16'(clk_sel), 16'd0);
        run_to(308);
        check("sw_clk_sel_t8", 16'(clk_sel), 16'd0);
        tick();
        check("sw_clk_sel_t9", 16'(clk_sel), 16'd1);
        check("sw_sys_rst_t9", 16'(sys_rst), 16'd1);
        run_to(316);
        check("sw_sys_rst_t16", 16'(sys_rst), 16'd1);
        tick();
        check("sw_sys_rst_t17", 16'(sys_rst), 16'd0);
        check("sw_ready_t17", 16'(ready), 16'd1);
        check("sw_pll_rst_t17", 16'(pll_rst), 16'd0);

        // Reset pulse while in RUN; lock is already present so the restart is short.
        run_to(330);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cyc = 0;
        check("rrun_pll_rst", 16'(pll_rst), 16'd1);
        check("rrun_sys_rst", 16'(sys_rst), 16'd1);
        check("rrun_ready", 16'(ready), 16'd0);
        check("rrun_retry", 16'(retry_cnt), 16'd0);
        check("rrun_clk_sel", 16'(clk_sel), 16'd1);
        run_to(272);
        check("rrun_ready_c272", 16'(ready), 16'd0);
        tick();
        check("rrun_ready_c273", 16'(ready), 16'd1);

        // One-cycle lock glitch at STABLE count 100 restarts the full stable count.
        chip_model = 1'b0;
        pll_locked = 1'b0;
        do_reset();
        check("g_clk_sel_c0", 16'(clk_sel), 16'd0);
        run_to(30);
        pll_locked = 1'b1;
        run_to(133);
        check("g_state_c133", 16'(dbg_state), 16'(ST_STABLE));
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        run_to(135);
        check("g_state_c135", 16'(dbg_state), 16'(ST_STABLE));
        tick();
        check("g_state_c136", 16'(dbg_state), 16'(ST_WAIT_LOCK));
        tick();
        check("g_state_c137", 16'(dbg_state), 16'(ST_STABLE));
        run_to(289);
        check("g_ready_c289", 16'(ready), 16'd0);
        run_to(392);
        check("g_ready_c392", 16'(ready), 16'd0);
        tick();
        check("g_ready_c393", 16'(ready), 16'd1);

        // Lock loss in RUN.
        run_to(400);
        pll_locked = 1'b0;
        run_to(402);
        check("ll_ready_c402", 16'(ready), 16'd1);
        tick();
        check("ll_pll_rst_c403", 16'(pll_rst), 16'd1);
        check("ll_sys_rst_c403", 16'(sys_rst), 16'd1);
        check("ll_ready_c403", 16'(ready), 16'd0);

        // Model change during PLL_RST is deferred until RUN; then lock loss inside SW_PRE.
        run_to(405);
        chip_model = 1'b1;
        run_to(410);
        pll_locked = 1'b1;
        run_to(675);
        check("df_clk_sel_c675", 16'(clk_sel), 16'd0);
        check("df_ready_c675", 16'(ready), 16'd0);
        tick();
        check("df_ready_c676", 16'(ready), 16'd1);
        check("df_clk_sel_c676", 16'(clk_sel), 16'd0);
        tick();
        check("df_state_c677", 16'(dbg_state), 16'(ST_SW_PRE));
        check("df_sys_rst_c677", 16'(sys_rst), 16'd1);
        run_to(679);
        pll_locked = 1'b0;
        run_to(681);
        check("sp_state_c681", 16'(dbg_state), 16'(ST_SW_PRE));
        tick();
        check("sp_pll_rst_c682", 16'(pll_rst), 16'd1);
        check("sp_clk_sel_c682", 16'(clk_sel), 16'd0);
        run_to(697);
        check("sp_pll_rst_c697", 16'(pll_rst), 16'd1);
        tick();
        check("sp_pll_rst_c698", 16'(pll_rst), 16'd0);
        check("sp_clk_sel_c698", 16'(clk_sel), 16'd0);

        // Lock never arrives.
        pll_locked = 1'b0;
        do_reset();
`ifdef CLKGEN_LOCK_TIMEOUT_EN
        for (int k = 1; k <= 16; k++) begin
            run_to(k * 4112 - 1);
            check("to_pll_rst_before", 16'(pll_rst), 16'd0);
            check("to_retry_before", 16'(retry_cnt), 16'((k - 1 > 15) ? 15 : k - 1));
            tick();
            check("to_pll_rst_at", 16'(pll_rst), 16'd1);
            check("to_retry_at", 16'(retry_cnt), 16'((k > 15) ? 15 : k));
        end
`else
        run_to(5000);
        check("nl_pll_rst", 16'(pll_rst), 16'd0);
        check("nl_retry", 16'(retry_cnt), 16'd0);
        check("nl_state", 16'(dbg_state), 16'(ST_WAIT_LOCK));
        check("nl_sys_rst", 16'(sys_rst), 16'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dot4x_clk_ctrl.md
DOT4X_CLK_CTRL -- requirements
Module: dot4x_clk_ctrl

Interface
REQ-001 SHALL have parameter PLL_RST_CYCLES, default 16: cycles the PLL reset is held high.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 4096: cycles to wait for lock before retrying.
REQ-003 SHALL have parameter STABLE_CYCLES, default 256: consecutive locked cycles required before release.
REQ-004 SHALL have parameter SWITCH_CYCLES, default 8: guard cycles before and after a clock-select change.
REQ-005 SHALL have port clk_col8x, input, 1: sole clock (free-running 8x colour clock, the PLL input).
REQ-006 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port chip_model, input, 1: 0 = NTSC (CLK0), 1 = PAL (CLK1); synchronous to clk_col8x.
REQ-008 SHALL have port pll_locked, input, 1: PLL LOCKED, asynchronous.
REQ-009 SHALL have port pll_rst, output, 1: drives PLL RST.
REQ-010 SHALL have port clk_sel, output, 1: dot4x BUFGMUX select.
REQ-011 SHALL have port sys_rst, output, 1: reset to dot4x logic.
REQ-012 SHALL have port ready, output, 1: clocks valid, sys_rst released.
REQ-013 SHALL have port retry_cnt, output, 4: saturating count of lock timeouts.

Function
REQ-014 SHALL synchronise pll_locked through two flops (locked_s); all decisions use locked_s (2-cycle latency).
REQ-015 SHALL implement states PLL_RST, WAIT_LOCK, STABLE, RUN, SW_PRE, SW_POST; all outputs registered.
REQ-016 PLL_RST: pll_rst=1, sys_rst=1, ready=0; after exactly PLL_RST_CYCLES cycles -> WAIT_LOCK, counter cleared.
REQ-017 WAIT_LOCK: pll_rst=0; locked_s=1 -> STABLE with counter cleared.
REQ-018 STABLE: counts cycles with locked_s=1; locked_s=0 -> WAIT_LOCK; count reaches STABLE_CYCLES -> RUN.
REQ-019 RUN: sys_rst=0, ready=1 from the first RUN cycle.
REQ-020 RUN: locked_s=0 -> PLL_RST next cycle, sys_rst=1 and ready=0 that same next cycle.
REQ-021 RUN: chip_model != clk_sel -> SW_PRE; sys_rst=1, ready=0; clk_sel unchanged.
REQ-022 SW_PRE: after SWITCH_CYCLES cycles, clk_sel takes chip_model and state -> SW_POST.
REQ-023 SW_POST: after SWITCH_CYCLES cycles -> RUN; chip_model then differing again re-enters SW_PRE.
REQ-024 Lock loss SHALL take precedence over a model change in RUN, SW_PRE and SW_POST (-> PLL_RST).
REQ-025 clk_sel SHALL change only at the SW_PRE->SW_POST transition, or at reset.
REQ-026 chip_model changes outside RUN SHALL NOT change clk_sel; they are acted on after RUN is reached.
REQ-027 Counters SHALL be wide enough for the largest parameter and SHALL NOT wrap within a state.

Reset
REQ-028 On rst: state=PLL_RST, counter=0, pll_rst=1, sys_rst=1, ready=0, retry_cnt=0, clk_sel=chip_model, sync flops=0.
REQ-029 rst asserted mid-operation (any state) SHALL restart the full sequence on the next cycle.

Configuration
REQ-030 Macro CLKGEN_LOCK_TIMEOUT_EN defined: WAIT_LOCK counter reaching LOCK_TIMEOUT -> PLL_RST and retry_cnt increments, saturating at 15.
REQ-031 Macro CLKGEN_LOCK_TIMEOUT_EN undefined: WAIT_LOCK waits indefinitely; retry_cnt is constant 0.

Verification
REQ-032 Reset release, pll_locked high at cycle 30 -> pll_rst high cycles 0-15, ready=1 at cycle 30+2+256 (+/-1 per documented pipelining), clk_sel=chip_model.
REQ-033 In STABLE, pll_locked dropped for 1 cycle at count 100 -> return to WAIT_LOCK; full 256-cycle count restarts; no premature ready.
REQ-034 In RUN, chip_model 0->1 -> sys_rst=1 next cycle, clk_sel=1 after 8 cycles, sys_rst=0 8 cycles later, pll_rst stays 0.
REQ-035 In SW_PRE, pll_locked dropped -> PLL_RST next cycle; pll_rst high for 16 cycles; clk_sel unchanged.
REQ-036 With CLKGEN_LOCK_TIMEOUT_EN, pll_locked held low -> pll_rst pulses every 16+4096 cycles; retry_cnt 1,2,...,15, then holds at 15.
REQ-037 rst pulsed while in RUN -> next cycle pll_rst=1, sys_rst=1, ready=0, retry_cnt=0.
